// File: rtl/rf_adc_timed_capture.sv
// rf_adc_timed_capture
//   Captures a commanded burst of 64-bit ADC words ({Q1,I1,Q0,I0}) from a
//   stream with no backpressure. A burst starts either at the next valid word
//   or at a given word timestamp. The captured words go into a small FIFO,
//   which is presented as an AXI-Stream with tlast and an error terminator.
//
// Ports
//   clk, rst                 data_clk domain clock and synchronous active-high reset
//   time_load/_value         load the word-time counter
//   time_now                 current word-time counter
//   cmd_valid/cmd_ready      command handshake (cmd_ready is high only in IDLE)
//   cmd_timed/cmd_time       timed start and its word timestamp
//   cmd_num_words            burst length; 0 = continuous until stop
//   stop                     ends continuous capture or aborts an armed command
//   i_tdata/i_tvalid         ADC stream (no ready)
//   o_tdata/o_tlast/o_terr   captured stream; o_terr marks an overflow terminator
//   o_tvalid/o_tready        output handshake
//   overflow/late            one-cycle status pulses
//   busy                     a command is in progress
//
// States
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no command; waiting for cmd_valid, ADC words ignored
//   ST_ARMED   | timed command; waiting for the word whose timestamp == cmd_time
//   ST_CAPTURE | writing every valid word until the count or stop ends the burst

module rf_adc_timed_capture #(
  parameter int FIFO_SIZE_LOG2 = 5,
  parameter int NUM_WORDS_W    = 16,
  parameter int TIME_W         = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   time_load,
  input  logic [TIME_W-1:0]      time_load_value,
  output logic [TIME_W-1:0]      time_now,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_timed,
  input  logic [TIME_W-1:0]      cmd_time,
  input  logic [NUM_WORDS_W-1:0] cmd_num_words,
  input  logic                   stop,
  input  logic [63:0]            i_tdata,
  input  logic                   i_tvalid,
  output logic [63:0]            o_tdata,
  output logic                   o_tlast,
  output logic                   o_terr,
  output logic                   o_tvalid,
  input  logic                   o_tready,
  output logic                   overflow,
  output logic                   late,
  output logic                   busy
);

  localparam int DEPTH  = 1 << FIFO_SIZE_LOG2;
  localparam int PTR_W  = FIFO_SIZE_LOG2;
  localparam int FILL_W = FIFO_SIZE_LOG2 + 1;
  localparam int ENT_W  = 66;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TIME_W-1:0]      time_q;
  logic [TIME_W-1:0]      cmd_time_q, cmd_time_d;
  logic [NUM_WORDS_W-1:0] rem_q, rem_d;
  logic                   cont_q, cont_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   cmd_ready_q;
  logic                   late_q, late_d;
  logic                   overflow_q;

  logic [ENT_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]      fill_q, fill_d;

  logic                   cap_req;
  logic                   cap_last;
  logic                   ovf;
  logic                   push;
  logic                   pop;
  logic [ENT_W-1:0]       push_word;

  // Word-time counter: the word's timestamp is the value before this
  // cycle's update, so a same-cycle load does not affect the current word.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= '0;
    end else if (time_load) begin
      time_q <= time_load_value;
    end else if (i_tvalid) begin
      time_q <= time_q + TIME_W'(1);
    end
  end

  // Next-state and capture decision. rem_q counts the words still to be
  // written in counted mode; it is loaded with the burst length at accept.
  always_comb begin
    state_d     = state_q;
    cmd_time_d  = cmd_time_q;
    rem_d       = rem_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    cap_req     = 1'b0;
    cap_last    = 1'b0;
    late_d      = 1'b0;
    ovf         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_time_d  = cmd_time;
          rem_d       = cmd_num_words;
          cont_d      = (cmd_num_words == '0);
          stop_pend_d = 1'b0;
          state_d     = cmd_timed ? ST_ARMED : ST_CAPTURE;
        end
      end

      ST_ARMED: begin
        // stop takes precedence over a word arriving in the same cycle
        if (stop) begin
          state_d = ST_IDLE;
        end else if (i_tvalid) begin
          if (time_q == cmd_time_q) begin
            cap_req  = 1'b1;
            cap_last = !cont_q && (rem_q == NUM_WORDS_W'(1));
            state_d  = cap_last ? ST_IDLE : ST_CAPTURE;
          end else if (time_q > cmd_time_q) begin
            late_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_CAPTURE: begin
        // In continuous mode a stop without a word is remembered and closes
        // the burst on the next valid word; with a word it closes that word.
        if (cont_q && stop) begin
          stop_pend_d = 1'b1;
        end
        if (i_tvalid) begin
          cap_req  = 1'b1;
          cap_last = cont_q ? (stop_pend_q || stop) : (rem_q == NUM_WORDS_W'(1));
          if (cap_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cap_req) begin
      rem_d = rem_q - NUM_WORDS_W'(1);
    end

    // One FIFO slot is held back so an overflow can always be closed with
    // a terminator; reaching it ends the burst.
    if (cap_req && (fill_q >= FILL_W'(DEPTH - 1))) begin
      ovf     = 1'b1;
      state_d = ST_IDLE;
    end
  end

  assign pop = (fill_q != '0) && o_tready;

  // On overflow the data word is dropped and a terminator goes in instead.
  // If the FIFO is completely full (an earlier terminator still unread) and
  // nothing leaves this cycle, there is no room and the terminator is lost.
  assign push      = cap_req && (!ovf || (fill_q != FILL_W'(DEPTH)) || pop);
  assign push_word = ovf ? {1'b1, 1'b1, 64'd0} : {1'b0, cap_last, i_tdata};

  always_comb begin
    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_time_q  <= '0;
      rem_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      late_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_time_q  <= cmd_time_d;
      rem_q       <= rem_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      // Ready only after a full cycle in IDLE, and dropped as soon as a
      // command is taken.
      cmd_ready_q <= (state_q == ST_IDLE) && (state_d == ST_IDLE);
      late_q      <= late_d;
      overflow_q  <= ovf;
      fill_q      <= fill_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; the fill count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign time_now  = time_q;
  assign cmd_ready = cmd_ready_q;
  assign o_tvalid  = (fill_q != '0);
  assign o_tdata   = mem_q[rd_ptr_q][63:0];
  assign o_tlast   = mem_q[rd_ptr_q][64];
  assign o_terr    = mem_q[rd_ptr_q][65];
  assign overflow  = overflow_q;
  assign late      = late_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_adc_timed_capture.sv
// tb_rf_adc_timed_capture
//   Random and directed stimulus for rf_adc_timed_capture. Expected output
//   entries are derived from the burst rules: which input words fall inside
//   the commanded window (by count or by timestamp), where the last word is,
//   and where an overflow terminator must appear.

module tb_rf_adc_timed_capture;

  localparam int FSL   = 5;
  localparam int NWW   = 16;
  localparam int TW    = 64;
  localparam int DEPTH = 1 << FSL;

  logic           clk = 1'b0;
  logic           rst;
  logic           time_load;
  logic [TW-1:0]  time_load_value;
  logic [TW-1:0]  time_now;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_timed;
  logic [TW-1:0]  cmd_time;
  logic [NWW-1:0] cmd_num_words;
  logic           stop;
  logic [63:0]    i_tdata;
  logic           i_tvalid;
  logic [63:0]    o_tdata;
  logic           o_tlast;
  logic           o_terr;
  logic           o_tvalid;
  logic           o_tready;
  logic           overflow;
  logic           late;
  logic           busy;

  rf_adc_timed_capture #(
    .FIFO_SIZE_LOG2 (FSL),
    .NUM_WORDS_W    (NWW),
    .TIME_W         (TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .time_load       (time_load),
    .time_load_value (time_load_value),
    .time_now        (time_now),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_timed       (cmd_timed),
    .cmd_time        (cmd_time),
    .cmd_num_words   (cmd_num_words),
    .stop            (stop),
    .i_tdata         (i_tdata),
    .i_tvalid        (i_tvalid),
    .o_tdata         (o_tdata),
    .o_tlast         (o_tlast),
    .o_terr          (o_terr),
    .o_tvalid        (o_tvalid),
    .o_tready        (o_tready),
    .overflow        (overflow),
    .late            (late),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: word-time counter and expected output entries.
  logic [TW-1:0] model_time;
  logic [65:0]   exp_q [$];
  logic [65:0]   got_q [$];
  int            late_cnt;
  int            ovf_cnt;

  bit            rdy_rand;
  bit            rdy_fix;

  // Output monitor and hold-stability check under backpressure.
  logic          hold_v;
  logic [65:0]   hold_e;
  always @(negedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v && o_tvalid) begin
        check_eq("hold_stable", {o_terr, o_tlast, o_tdata}, hold_e);
      end
      hold_v <= o_tvalid && !o_tready;
      hold_e <= {o_terr, o_tlast, o_tdata};
      if (o_tvalid && o_tready) got_q.push_back({o_terr, o_tlast, o_tdata});
      if (late) late_cnt++;
      if (overflow) ovf_cnt++;
    end
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input bit v, input bit s, output logic [63:0] d);
    d        = {$urandom(), $urandom()};
    i_tvalid = v;
    i_tdata  = d;
    stop     = s;
    tick();
    if (v) model_time = model_time + 64'd1;
    i_tvalid = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic load_time(input logic [TW-1:0] v, input bit with_word);
    logic [63:0] d;
    time_load       = 1'b1;
    time_load_value = v;
    drive_word(with_word, 1'b0, d);
    time_load       = 1'b0;
    model_time      = v;
    check_eq("time_load", 66'(time_now), 66'(v));
  endtask

  task automatic send_cmd(input bit timed, input logic [TW-1:0] t, input int n);
    bit ok = 1'b0;
    cmd_valid     = 1'b1;
    cmd_timed     = timed;
    cmd_time      = t;
    cmd_num_words = NWW'(n);
    for (int k = 0; k < 100; k++) begin
      ok = cmd_ready;
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    check_eq("cmd_accept", 66'(ok), 66'(1));
  endtask

  task automatic drain_compare(input string tag);
    int n = exp_q.size();
    for (int k = 0; k < 3000; k++) begin
      if (got_q.size() >= n && !o_tvalid) break;
      tick();
    end
    check_eq({tag, "_count"}, 66'(got_q.size()), 66'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq({tag, "_entry"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // mode 0: immediate counted, 1: timed counted, 2: continuous with stop
  task automatic run_burst(input int mode, input int n, input int offset, input bit gaps);
    logic [TW-1:0] t0;
    logic [TW-1:0] ts;
    logic [63:0]   d;
    int            captured = 0;
    int            total;
    bit            in_win;
    bit            is_last;
    bit            stop_with_word;
    t0 = model_time + TW'(offset);
    send_cmd(mode == 1, t0, (mode == 2) ? 0 : n);
    total = (mode == 1) ? (offset + n + 2) : (n + 3);
    stop_with_word = ($urandom_range(0, 1) == 1);
    for (int w = 0; w < total; w++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) drive_word(1'b0, 1'b0, d);
      end
      ts = model_time;
      if (mode == 1) begin
        in_win  = (ts >= t0) && (ts < t0 + TW'(n));
        is_last = (ts == t0 + TW'(n - 1));
      end else begin
        in_win  = (w < n + 1) && (mode == 2 || w < n);
        is_last = (mode == 2) ? (w == n) : (w == n - 1);
      end
      if (mode == 2 && w == n && !stop_with_word) begin
        drive_word(1'b0, 1'b1, d);
        drive_word(1'b0, 1'b0, d);
      end
      if (in_win && captured == 0) check_eq("early_valid", 66'(o_tvalid), 66'(0));
      if (in_win && is_last) check_eq("busy_before_last", 66'(busy), 66'(1));
      drive_word(1'b1, (mode == 2 && w == n && stop_with_word), d);
      if (in_win) begin
        exp_q.push_back({1'b0, is_last, d});
        if (captured == 0) check_eq("first_latency", 66'(o_tvalid), 66'(1));
        captured++;
        if (is_last) check_eq("busy_after_last", 66'(busy), 66'(0));
      end
    end
    drain_compare("burst");
  endtask

  initial begin
    logic [63:0] d;
    int          late0;
    rst = 1'b1; time_load = 1'b0; time_load_value = '0;
    cmd_valid = 1'b0; cmd_timed = 1'b0; cmd_time = '0; cmd_num_words = '0;
    stop = 1'b0; i_tdata = '0; i_tvalid = 1'b0;
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    model_time = '0; late_cnt = 0; ovf_cnt = 0;
    hold_v = 1'b0; hold_e = '0;

    // Reset values
    repeat (3) tick();
    check_eq("rst_cmd_ready", 66'(cmd_ready), 66'(0));
    check_eq("rst_tvalid", 66'(o_tvalid), 66'(0));
    check_eq("rst_busy", 66'(busy), 66'(0));
    check_eq("rst_overflow", 66'(overflow), 66'(0));
    check_eq("rst_late", 66'(late), 66'(0));
    check_eq("rst_time", 66'(time_now), 66'(0));
    rst = 1'b0;
    tick();
    check_eq("post_rst_cmd_ready", 66'(cmd_ready), 66'(1));

    // Immediate burst of 4 with continuous valid
    run_burst(0, 4, 0, 1'b0);

    // Timed start at 110 after loading 100
    load_time(64'd100, 1'b0);
    run_burst(1, 3, 10, 1'b0);

    // Late command
    load_time(64'd200, 1'b0);
    late_cnt = 0;
    send_cmd(1'b1, 64'd150, 5);
    drive_word(1'b1, 1'b0, d);
    check_eq("late_pulse", 66'(late), 66'(1));
    check_eq("late_busy", 66'(busy), 66'(0));
    tick();
    check_eq("late_once", 66'(late), 66'(0));
    check_eq("late_count", 66'(late_cnt), 66'(1));
    check_eq("late_cmd_ready", 66'(cmd_ready), 66'(1));
    check_eq("late_no_output", 66'(o_tvalid), 66'(0));

    // Overflow with downstream stalled
    rdy_fix = 1'b0;
    tick();
    ovf_cnt = 0;
    send_cmd(1'b0, '0, 100);
    for (int w = 0; w < 40; w++) begin
      drive_word(1'b1, 1'b0, d);
      if (w < DEPTH - 1) exp_q.push_back({2'b00, d});
    end
    exp_q.push_back({2'b11, 64'd0});
    check_eq("ovf_count", 66'(ovf_cnt), 66'(1));
    check_eq("ovf_busy", 66'(busy), 66'(0));
    check_eq("ovf_held", 66'(got_q.size()), 66'(0));
    rdy_fix = 1'b1;
    drain_compare("ovf");

    // Continuous bursts ended by stop
    run_burst(2, 5, 0, 1'b0);
    run_burst(2, 3, 0, 1'b1);

    // Stop in ARMED wins over the matching word
    late0 = late_cnt;
    send_cmd(1'b1, model_time + 64'd3, 2);
    for (int w = 0; w < 3; w++) drive_word(1'b1, 1'b0, d);
    drive_word(1'b1, 1'b1, d);
    check_eq("armed_stop_busy", 66'(busy), 66'(0));
    for (int w = 0; w < 6; w++) drive_word(1'b1, 1'b0, d);
    check_eq("armed_stop_no_output", 66'(got_q.size()), 66'(0));
    check_eq("armed_stop_no_late", 66'(late_cnt), 66'(late0));
    check_eq("armed_stop_time", 66'(time_now), 66'(model_time));

    // Load coincident with a word: the load wins
    load_time(64'h1234_5678_0000_0000, 1'b1);

    // Randomized bursts with random backpressure
    rdy_rand = 1'b1;
    for (int it = 0; it < 12; it++) begin
      run_burst($urandom_range(0, 2), $urandom_range(1, 20), $urandom_range(0, 6), 1'b1);
      check_eq("rand_time", 66'(time_now), 66'(model_time));
    end
    rdy_rand = 1'b0;

    // Reset in the middle of a capture with 10 words buffered
    rdy_fix = 1'b0;
    tick();
    send_cmd(1'b0, '0, 20);
    for (int w = 0; w < 10; w++) drive_word(1'b1, 1'b0, d);
    check_eq("mid_buffered", 66'(o_tvalid), 66'(1));
    rst = 1'b1;
    tick();
    check_eq("mid_rst_tvalid", 66'(o_tvalid), 66'(0));
    check_eq("mid_rst_time", 66'(time_now), 66'(0));
    check_eq("mid_rst_cmd_ready", 66'(cmd_ready), 66'(0));
    rst = 1'b0;
    model_time = '0;
    rdy_fix = 1'b1;
    tick();
    check_eq("mid_post_cmd_ready", 66'(cmd_ready), 66'(1));
    check_eq("mid_post_busy", 66'(busy), 66'(0));
    repeat (3) tick();
    check_eq("mid_no_output", 66'(got_q.size()), 66'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
